// File: rtl/mf_disp_fill_eng.sv
// Rectangle-fill engine merged with CPU writes into one registered write stream.
// MF_DISP_FILL_CLIP_EN: clip fill rectangles to the frame in SETUP.
module mf_disp_fill_eng #(
  parameter logic [15:0] FB_BASE    = 16'h0000,
  parameter int          LINE_WORDS = 80,
  parameter int          NUM_ROWS   = 240
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        cpu_wr_vld,
  input  logic [15:0] cpu_wr_addr,
  input  logic [31:0] cpu_wr_data,
  output logic        cpu_wr_rdy,
  input  logic        fill_start,
  input  logic [6:0]  fill_x0,
  input  logic [7:0]  fill_y0,
  input  logic [6:0]  fill_w,
  input  logic [7:0]  fill_h,
  input  logic [7:0]  fill_color,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        sys_wr_vld,
  output logic [15:0] sys_wr_addr,
  output logic [31:0] sys_wr_data
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN,
    DONE
  } state_t;

  localparam logic [15:0] LW = 16'(LINE_WORDS);

  state_t      state;
  state_t      state_n;
  logic [6:0]  x0_q;
  logic [6:0]  w_q;
  logic [7:0]  y0_q;
  logic [7:0]  h_q;
  logic [7:0]  color_q;
  logic [6:0]  cols_q;
  logic [7:0]  rows_q;
  logic [6:0]  col;
  logic [7:0]  row;
  logic [15:0] row_base;
  logic        last_cpu;
  logic [6:0]  cols_n;
  logic [7:0]  rows_n;
  logic [15:0] base_n;
  logic        cpu_gnt;
  logic        eng_gnt;
  logic        col_last;
  logic        row_last;

`ifdef MF_DISP_FILL_CLIP_EN
  localparam logic [15:0] NR = 16'(NUM_ROWS);
  logic [15:0] col_room;
  logic [15:0] row_room;

  always_comb begin
    col_room = LW - {9'd0, x0_q};
    row_room = NR - {8'd0, y0_q};
    cols_n   = 7'd0;
    rows_n   = 8'd0;
    if ({9'd0, x0_q} < LW)
      cols_n = ({9'd0, w_q} < col_room) ? w_q : col_room[6:0];
    if ({8'd0, y0_q} < NR)
      rows_n = ({8'd0, h_q} < row_room) ? h_q : row_room[7:0];
  end
`else
  always_comb begin
    cols_n = w_q;
    rows_n = h_q;
  end
`endif

  assign base_n = FB_BASE
                + 16'(32'(y0_q) * 32'(LINE_WORDS))
                + {9'd0, x0_q};

  // CPU yields only when the engine is waiting and the CPU went last
  assign cpu_wr_rdy = !(state == RUN && last_cpu);
  assign cpu_gnt    = cpu_wr_vld & cpu_wr_rdy;
  assign eng_gnt    = (state == RUN) & ~cpu_gnt;
  assign col_last   = (col == cols_q - 7'd1);
  assign row_last   = (row == rows_q - 8'd1);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    fill_busy = 1'b0;
    fill_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (fill_start) state_n = SETUP;
      end
      SETUP: begin
        fill_busy = 1'b1;
        if (cols_n == 7'd0 || rows_n == 8'd0) state_n = DONE;
        else                                  state_n = RUN;
      end
      RUN: begin
        fill_busy = 1'b1;
        if (eng_gnt && col_last && row_last) state_n = DONE;
      end
      DONE: begin
        fill_done = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      x0_q     <= '0;
      w_q      <= '0;
      y0_q     <= '0;
      h_q      <= '0;
      color_q  <= '0;
      cols_q   <= '0;
      rows_q   <= '0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else begin
      if (state == IDLE && fill_start) begin
        x0_q    <= fill_x0;
        w_q     <= fill_w;
        y0_q    <= fill_y0;
        h_q     <= fill_h;
        color_q <= fill_color;
      end
      if (state == SETUP) begin
        cols_q   <= cols_n;
        rows_q   <= rows_n;
        row_base <= base_n;
        col      <= '0;
        row      <= '0;
      end
      if (eng_gnt) begin
        if (col_last) begin
          col      <= '0;
          row      <= row + 8'd1;
          row_base <= row_base + LW;
        end else begin
          col <= col + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      last_cpu    <= 1'b0;
      sys_wr_vld  <= 1'b0;
      sys_wr_addr <= '0;
      sys_wr_data <= '0;
    end else begin
      sys_wr_vld <= cpu_gnt | eng_gnt;
      if (cpu_gnt | eng_gnt) last_cpu <= cpu_gnt;
      if (cpu_gnt) begin
        sys_wr_addr <= cpu_wr_addr;
        sys_wr_data <= cpu_wr_data;
      end else if (eng_gnt) begin
        sys_wr_addr <= row_base + {9'd0, col};
        sys_wr_data <= {4{color_q}};
      end
    end
  end

endmodule

// File: tb/tb_mf_disp_fill_eng.sv
// Directed bench for mf_disp_fill_eng: table of fills plus
// contention, restart-while-busy and reset-mid-fill sequences.
module tb_mf_disp_fill_eng;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        cpu_wr_vld;
  logic [15:0] cpu_wr_addr;
  logic [31:0] cpu_wr_data;
  logic        cpu_wr_rdy;
  logic        fill_start;
  logic [6:0]  fill_x0;
  logic [7:0]  fill_y0;
  logic [6:0]  fill_w;
  logic [7:0]  fill_h;
  logic [7:0]  fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic        sys_wr_vld;
  logic [15:0] sys_wr_addr;
  logic [31:0] sys_wr_data;

  mf_disp_fill_eng dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .cpu_wr_vld  (cpu_wr_vld),
    .cpu_wr_addr (cpu_wr_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_wr_rdy  (cpu_wr_rdy),
    .fill_start  (fill_start),
    .fill_x0     (fill_x0),
    .fill_y0     (fill_y0),
    .fill_w      (fill_w),
    .fill_h      (fill_h),
    .fill_color  (fill_color),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .sys_wr_vld  (sys_wr_vld),
    .sys_wr_addr (sys_wr_addr),
    .sys_wr_data (sys_wr_data)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [6:0] x0;
    logic [7:0] y0;
    logic [6:0] w;
    logic [7:0] h;
    logic [7:0] c;
    int         k;
    int         fa;
    int         la;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        vlog  [4096];
  logic [15:0] alog  [4096];
  logic [31:0] dlog  [4096];
  logic        rlog  [4096];
  logic        blog  [4096];
  logic        dnlog [4096];

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (cyc < 4096) begin
      vlog[cyc]  = sys_wr_vld;
      alog[cyc]  = sys_wr_addr;
      dlog[cyc]  = sys_wr_data;
      rlog[cyc]  = cpu_wr_rdy;
      blog[cyc]  = fill_busy;
      dnlog[cyc] = fill_done;
    end
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    fill_x0    = v.x0;
    fill_y0    = v.y0;
    fill_w     = v.w;
    fill_h     = v.h;
    fill_color = v.c;
  endtask

  task automatic wait_done(input string n, output int dc);
    bit seen;
    seen = 0;
    dc   = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge sys_clk);
      if (fill_done) begin
        seen = 1;
        dc   = cyc;
      end
    end
    chk({n, ".done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic run_fill(input vec_t v, input string n, output int t0);
    int dc, cnt, nd, fa, la;
    logic [31:0] fd;
    t0 = cyc;
    drive(v);
    fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    chk({n, ".busy_setup"}, {31'd0, fill_busy}, 32'd1);
    wait_done(n, dc);
    repeat (3) @(negedge sys_clk);
    cnt = 0;
    nd  = 0;
    fa  = -1;
    la  = -1;
    fd  = '0;
    for (int c = t0 + 1; c < cyc; c++) begin
      if (dnlog[c]) nd++;
      if (vlog[c]) begin
        if (cnt == 0) begin
          fa = int'(alog[c]);
          fd = dlog[c];
        end
        la = int'(alog[c]);
        cnt++;
      end
    end
    chk({n, ".count"}, cnt, v.k);
    chk({n, ".done_cyc"}, dc - t0, v.k + 2);
    chk({n, ".done_cnt"}, nd, 1);
    chk({n, ".busy_at_done"}, {31'd0, blog[dc]}, 32'd0);
    if (v.k > 0) begin
      chk({n, ".first_addr"}, fa, v.fa);
      chk({n, ".last_addr"}, la, v.la);
      chk({n, ".data"}, fd, {4{v.c}});
      chk({n, ".first_cyc"}, {31'd0, vlog[t0 + 3]}, 32'd1);
    end
    tick;
  endtask

  vec_t vt[8];
  int   fs[4];

  initial begin
    int t0, dc, nv, nd;
    vt[0] = '{7'd2,  8'd3,   7'd2, 8'd2, 8'hA5, 4, 242,   323};
    vt[1] = '{7'd0,  8'd0,   7'd1, 8'd1, 8'h3C, 1, 0,     0};
    vt[2] = '{7'd0,  8'd5,   7'd0, 8'd5, 8'h11, 0, 0,     0};
    vt[3] = '{7'd78, 8'd239, 7'd2, 8'd1, 8'hC3, 2, 19198, 19199};
    vt[4] = '{7'd10, 8'd100, 7'd3, 8'd3, 8'h01, 9, 8010,  8172};
    vt[5] = '{7'd1,  8'd1,   7'd5, 8'd0, 8'h22, 0, 0,     0};
`ifdef MF_DISP_FILL_CLIP_EN
    vt[6] = '{7'd79, 8'd238, 7'd3, 8'd4, 8'h5A, 2, 19119, 19199};
    vt[7] = '{7'd90, 8'd0,   7'd2, 8'd1, 8'h77, 0, 0,     0};
`else
    vt[6] = '{7'd79, 8'd238, 7'd3, 8'd4, 8'h5A, 12, 19119, 19361};
    vt[7] = '{7'd90, 8'd0,   7'd2, 8'd1, 8'h77, 2, 90,    91};
`endif
    fs = '{242, 243, 322, 323};

    reset       = 1'b1;
    cpu_wr_vld  = 1'b0;
    cpu_wr_addr = '0;
    cpu_wr_data = '0;
    fill_start  = 1'b0;
    drive(vt[1]);
    repeat (3) tick;
    chk("rst.vld", {31'd0, sys_wr_vld}, 32'd0);
    chk("rst.addr", {16'd0, sys_wr_addr}, 32'd0);
    chk("rst.data", sys_wr_data, 32'd0);
    chk("rst.busy", {31'd0, fill_busy}, 32'd0);
    chk("rst.done", {31'd0, fill_done}, 32'd0);
    chk("rst.rdy", {31'd0, cpu_wr_rdy}, 32'd1);
    reset = 1'b0;
    tick;

    for (int i = 0; i < 8; i++)
      run_fill(vt[i], $sformatf("vec%0d", i), t0);

    // exact uncontended write sequence
    run_fill(vt[0], "seq", t0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq.vld%0d", i), {31'd0, vlog[t0 + 3 + i]}, 32'd1);
      chk($sformatf("seq.addr%0d", i), {16'd0, alog[t0 + 3 + i]}, fs[i]);
    end

    // full contention with CPU held high
    cpu_wr_addr = 16'hF000;
    cpu_wr_data = 32'h12345678;
    cpu_wr_vld  = 1'b1;
    tick;
    tick;
    t0 = cyc;
    drive(vt[0]);
    fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    wait_done("cont", dc);
    repeat (3) @(negedge sys_clk);
    cpu_wr_vld = 1'b0;
    chk("cont.done_cyc", dc - t0, 9);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("cont.vld%0d", i), {31'd0, vlog[t0 + 3 + i]}, 32'd1);
      chk($sformatf("cont.addr%0d", i), {16'd0, alog[t0 + 3 + i]},
          (i % 2 == 0) ? fs[i / 2] : 32'hF000);
    end
    for (int i = 0; i < 7; i++)
      chk($sformatf("cont.rdy%0d", i), {31'd0, rlog[t0 + 2 + i]},
          (i % 2 == 0) ? 32'd0 : 32'd1);
    tick;

    // second start while busy must be ignored
    t0 = cyc;
    drive('{7'd0, 8'd0, 7'd4, 8'd4, 8'h44, 16, 0, 243});
    fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    repeat (3) tick;
    drive('{7'd50, 8'd50, 7'd9, 8'd9, 8'h99, 0, 0, 0});
    fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    wait_done("restart", dc);
    repeat (3) @(negedge sys_clk);
    nv = 0;
    for (int c = t0 + 1; c < cyc; c++) if (vlog[c]) nv++;
    chk("restart.count", nv, 16);
    chk("restart.done_cyc", dc - t0, 18);
    chk("restart.last_addr", {16'd0, alog[t0 + 18]}, 243);
    chk("restart.last_data", dlog[t0 + 18], 32'h44444444);
    tick;

    // reset after three writes of a 4x4 fill
    t0 = cyc;
    drive('{7'd0, 8'd0, 7'd4, 8'd4, 8'h66, 16, 0, 0});
    fill_start = 1'b1;
    tick;
    fill_start = 1'b0;
    repeat (4) tick;
    chk("rmid.vld_before", {31'd0, sys_wr_vld}, 32'd1);
    chk("rmid.addr2", {16'd0, sys_wr_addr}, 32'd2);
    reset = 1'b1;
    #1;
    chk("rmid.vld", {31'd0, sys_wr_vld}, 32'd0);
    chk("rmid.busy", {31'd0, fill_busy}, 32'd0);
    tick;
    reset = 1'b0;
    t0 = cyc;
    repeat (8) tick;
    nv = 0;
    nd = 0;
    for (int c = t0; c < cyc; c++) begin
      if (vlog[c]) nv++;
      if (dnlog[c]) nd++;
    end
    chk("rmid.no_writes", nv, 0);
    chk("rmid.no_done", nd, 0);
    run_fill(vt[4], "after_rst", t0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
